cache_bist: RTL and testbench
=============================

# cache_bist

Built-in self-test initiator for the cache's client port. It drives the cache's CPU-side request interface (enable / address / write_enable / data_in) and consumes its responses (data_out / data_out_ready / busy). It runs a four-pass write/verify sequence over a configurable address window and reports pass/fail with first-error capture. It sits in place of the CPU during board bring-up, with the cache and burst RAM underneath unchanged.

## Interface
- AddressBitWidth, 4, window is 2^AddressBitWidth 32-bit words at byte addresses 0 .. 4·(2^AddressBitWidth − 1)
- Seed, 32'h0000_0000, XOR-ed into every pattern word
- TimeoutCycles, 1024, max cycles any single transaction may wait before a timeout error
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; starts a run when in Idle or Done
- done  out  1  run finished (pass or fail); held until next start or reset
- error  out  1  valid with done; 1 = failure
- err_timeout  out  1  failure was a timeout, not a data mismatch
- err_address  out  32  byte address of first failure
- err_expected  out  32  expected word at failure
- err_actual  out  32  ca_data_out at failure (0 on timeout)
- ca_enable  out  1  to cache enable
- ca_write_enable  out  4  byte-lane write strobes; 0 = read
- ca_address  out  32  byte address, always word aligned
- ca_data_in  out  32  write data to cache
- ca_data_out  in  32  read data from cache
- ca_data_out_ready  in  1  ca_data_out valid
- ca_busy  in  1  cache cannot accept a request

## Operation
- pattern(a) = {a[15:0], ~a[15:0]} ^ Seed; a is the byte address.
- Pass W0: ascending word index. Full-word write of pattern(a), strobes 4'b1111.
- Pass R0: ascending. Read and compare against pattern(a).
- Pass W1: descending. Two half-word writes per word, both carrying data ~pattern(a): first with strobes 4'b0011, then 4'b1100.
- Pass R1: ascending. Read and compare against ~pattern(a).
- Transactions per run: 5·2^AddressBitWidth.
- FSM states: Idle, Issue, WaitWrite, WaitRead, Next, Done.
- Idle: ca_enable=0. On start → Issue with index=0, pass=W0.
- Issue: drive ca_enable=1, address, strobes and data.
  - A request is accepted on the first rising edge with ca_busy=0.
  - On acceptance, go to WaitWrite if strobes≠0, else WaitRead.
- WaitWrite: hold all request ports stable. On the first edge with ca_busy=0 → Next.
- WaitRead: hold request ports stable. On the first edge with ca_data_out_ready=1, compare ca_data_out.
  - Match → Next.
  - Mismatch → capture err_*, error=1 → Done.
- Next: ca_enable=0, ca_write_enable=0. Advance half-word step / index / pass → Issue. After the last R1 read → Done with error=0.
- Timeout: a 32-bit wait counter clears on entering Issue and counts in Issue, WaitWrite and WaitRead. When it reaches TimeoutCycles: error=1, err_timeout=1, err_address=current address, err_actual=0 → Done.
- start while not in Idle/Done is ignored.
- start in Done clears done, error and all err_* outputs, then restarts from W0.
- Index wrap: W0/R0/R1 end after index 2^AddressBitWidth−1. W1 ends after index 0, then R1 starts at index 0.

## Timing
- Reset (async assert, sync release): Idle; every output 0, including ca_* and err_*.
- Reset mid-run returns to Idle immediately. No cleanup is issued to the cache; an in-flight cache operation completes on its own.
- start → ca_enable=1 on the next cycle.
- Minimum per transaction, hit case (Issue, Wait, Next): 3 cycles.
- done rises the cycle after the final compare, or at the timeout edge.
- Compare uses ca_data_out sampled in the same cycle as ca_data_out_ready=1.
- Request ports change only in Next or on entering Issue, never during WaitWrite/WaitRead.

## Structure
- Shared package: pass enum (W0, R0, W1, R1), state enum, and the pattern function.
- One sub-module, bist_pattern_gen: combinational. Inputs: address, pass, half-step. Outputs: data and strobes, so the generator can be tested alone.

## Test plan
- Reset with ca_busy=1: every output 0; hold 10 cycles, ca_enable stays 0.
- Cache + burst_ram (LineIndexBitWidth 1, 64-bit RAM words), AddressBitWidth=4, start → done=1, error=0; 80 accepted requests counted; strobe sequence on index 15 in W1 is 0011 then 1100.
- Same setup, bench flips bit 0 of ca_data_out on the R0 read of 0x14 → error=1, err_timeout=0, err_address=0x14, err_expected=0x0014FFEB, err_actual=0x0014FFEA.
- Stub cache with ca_busy stuck 1, TimeoutCycles=1024 → done after 1024 Issue cycles; error=1, err_timeout=1, err_address=0, err_actual=0.
- start pulsed mid-W1 → ignored, run completes normally. start in Done → err_* cleared, second run passes.
- rst_n low during R0 wait → all outputs 0 asynchronously. Release, then start → full pass.

Source files
------------

// File: rtl/cache_bist_pkg.sv
// Shared types for the cache BIST initiator: pass and state encodings plus
// the address-derived test pattern.
package cache_bist_pkg;

   typedef enum logic [1:0] {
      PASS_W0,
      PASS_R0,
      PASS_W1,
      PASS_R1
   } pass_t;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_ISSUE      = 3'd1;
   localparam state_t ST_WAIT_WRITE = 3'd2;
   localparam state_t ST_WAIT_READ  = 3'd3;
   localparam state_t ST_NEXT       = 3'd4;
   localparam state_t ST_DONE       = 3'd5;

   // Upper half carries the address, lower half its complement, so both
   // stuck-at polarities show up on every data line across the window.
   function automatic logic [31:0] bist_pattern(input logic [31:0] addr,
                                                input logic [31:0] seed);
      return {addr[15:0], ~addr[15:0]} ^ seed;
   endfunction

endpackage

// File: rtl/cache_bist_if.sv
// CPU-side request/response port of the cache, as seen by the BIST initiator.
interface cache_bist_if;

   logic        ca_enable;
   logic [3:0]  ca_write_enable;
   logic [31:0] ca_address;
   logic [31:0] ca_data_in;
   logic [31:0] ca_data_out;
   logic        ca_data_out_ready;
   logic        ca_busy;

   modport master (
      output ca_enable, ca_write_enable, ca_address, ca_data_in,
      input  ca_data_out, ca_data_out_ready, ca_busy
   );

   modport slave (
      input  ca_enable, ca_write_enable, ca_address, ca_data_in,
      output ca_data_out, ca_data_out_ready, ca_busy
   );

endinterface

// File: rtl/cache_bist_pattern_gen.sv
// Combinational generator of write data / expected data and byte strobes for
// one BIST transaction, given the address, pass and half-word step.
module bist_pattern_gen
   import cache_bist_pkg::*;
#(
   parameter logic [31:0] Seed = 32'h0000_0000
) (
   input  logic [31:0] address,
   input  pass_t       pass,
   input  logic        half_step,
   output logic [31:0] data,
   output logic [3:0]  strobes
);

   logic [31:0] base;

   assign base = bist_pattern(address, Seed);

   // Reads reuse the data output as the word the cache must return.
   always_comb begin
      data    = base;
      strobes = 4'b0000;
      case (pass)
         PASS_W0: strobes = 4'b1111;
         PASS_W1: begin
            data    = ~base;
            strobes = half_step ? 4'b1100 : 4'b0011;
         end
         PASS_R1: data = ~base;
         default: data = base;
      endcase
   end

endmodule

// File: rtl/cache_bist.sv
// BIST initiator: runs W0/R0/W1/R1 over the address window through the cache
// client port and reports pass/fail with first-error capture.
module cache_bist
   import cache_bist_pkg::*;
#(
   parameter int          AddressBitWidth = 4,
   parameter logic [31:0] Seed            = 32'h0000_0000,
   parameter int          TimeoutCycles   = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         done,
   output logic         error,
   output logic         err_timeout,
   output logic [31:0]  err_address,
   output logic [31:0]  err_expected,
   output logic [31:0]  err_actual,
   cache_bist_if.master ca
);

   localparam logic [AddressBitWidth-1:0] LastIndex = '1;

   state_t                     state;
   pass_t                      pass;
   logic [AddressBitWidth-1:0] index;
   logic                       half_step;
   logic [31:0]                wait_cnt;
   logic [31:0]                expected;

   pass_t                      gen_pass;
   logic [AddressBitWidth-1:0] gen_index;
   logic                       gen_half;
   logic [31:0]                gen_address;
   logic [31:0]                gen_data;
   logic [3:0]                 gen_strobes;

   pass_t                      nx_pass;
   logic [AddressBitWidth-1:0] nx_index;
   logic                       nx_half;
   logic                       last_txn;

   logic launch, in_wait, accept, write_done, read_done, timed_out;
   logic load_req, drop_req;

   assign launch     = start && (state == ST_IDLE || state == ST_DONE);
   assign in_wait    = (state == ST_ISSUE) || (state == ST_WAIT_WRITE) || (state == ST_WAIT_READ);
   assign accept     = (state == ST_ISSUE) && !ca.ca_busy;
   assign write_done = (state == ST_WAIT_WRITE) && !ca.ca_busy;
   assign read_done  = (state == ST_WAIT_READ) && ca.ca_data_out_ready;
   assign timed_out  = in_wait && !accept && !write_done && !read_done
                       && (wait_cnt == 32'(TimeoutCycles - 1));
   assign load_req   = launch || (state == ST_NEXT);
   assign drop_req   = write_done || read_done || timed_out;

   // A launch presents the first W0 word; otherwise the counters were already
   // advanced on the way into Next.
   assign gen_pass    = launch ? PASS_W0 : pass;
   assign gen_index   = launch ? '0 : index;
   assign gen_half    = launch ? 1'b0 : half_step;
   assign gen_address = {{(30-AddressBitWidth){1'b0}}, gen_index, 2'b00};

   bist_pattern_gen #(.Seed(Seed)) u_pattern_gen (
      .address   (gen_address),
      .pass      (gen_pass),
      .half_step (gen_half),
      .data      (gen_data),
      .strobes   (gen_strobes)
   );

   // W1 walks downwards and splits each word into two half-word writes.
   always_comb begin
      nx_pass  = pass;
      nx_index = index;
      nx_half  = half_step;
      last_txn = 1'b0;
      case (pass)
         PASS_W0: begin
            if (index == LastIndex) begin
               nx_pass  = PASS_R0;
               nx_index = '0;
            end else begin
               nx_index = index + 1'b1;
            end
         end
         PASS_R0: begin
            if (index == LastIndex) begin
               nx_pass  = PASS_W1;
               nx_index = LastIndex;
               nx_half  = 1'b0;
            end else begin
               nx_index = index + 1'b1;
            end
         end
         PASS_W1: begin
            if (!half_step) begin
               nx_half = 1'b1;
            end else begin
               nx_half = 1'b0;
               if (index == '0) begin
                  nx_pass  = PASS_R1;
                  nx_index = '0;
               end else begin
                  nx_index = index - 1'b1;
               end
            end
         end
         default: begin
            if (index == LastIndex) begin
               last_txn = 1'b1;
            end else begin
               nx_index = index + 1'b1;
            end
         end
      endcase
   end

   // Request ports only move when a request is loaded or dropped, so they stay
   // frozen throughout WaitWrite/WaitRead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ca.ca_enable       <= 1'b0;
         ca.ca_write_enable <= 4'b0000;
         ca.ca_address      <= '0;
         ca.ca_data_in      <= '0;
         expected           <= '0;
      end else if (load_req) begin
         ca.ca_enable       <= 1'b1;
         ca.ca_write_enable <= gen_strobes;
         ca.ca_address      <= gen_address;
         ca.ca_data_in      <= (|gen_strobes) ? gen_data : 32'h0;
         expected           <= gen_data;
      end else if (drop_req) begin
         ca.ca_enable       <= 1'b0;
         ca.ca_write_enable <= 4'b0000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         pass         <= PASS_W0;
         index        <= '0;
         half_step    <= 1'b0;
         wait_cnt     <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_timeout  <= 1'b0;
         err_address  <= '0;
         err_expected <= '0;
         err_actual   <= '0;
      end else if (launch) begin
         state        <= ST_ISSUE;
         pass         <= PASS_W0;
         index        <= '0;
         half_step    <= 1'b0;
         wait_cnt     <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_timeout  <= 1'b0;
         err_address  <= '0;
         err_expected <= '0;
         err_actual   <= '0;
      end else if (state == ST_NEXT) begin
         state    <= ST_ISSUE;
         wait_cnt <= '0;
      end else if (accept) begin
         state    <= (|ca.ca_write_enable) ? ST_WAIT_WRITE : ST_WAIT_READ;
         wait_cnt <= wait_cnt + 32'd1;
      end else if (write_done) begin
         state     <= ST_NEXT;
         pass      <= nx_pass;
         index     <= nx_index;
         half_step <= nx_half;
      end else if (read_done) begin
         if (ca.ca_data_out != expected) begin
            state        <= ST_DONE;
            done         <= 1'b1;
            error        <= 1'b1;
            err_address  <= ca.ca_address;
            err_expected <= expected;
            err_actual   <= ca.ca_data_out;
         end else if (last_txn) begin
            state <= ST_DONE;
            done  <= 1'b1;
         end else begin
            state     <= ST_NEXT;
            pass      <= nx_pass;
            index     <= nx_index;
            half_step <= nx_half;
         end
      end else if (timed_out) begin
         state        <= ST_DONE;
         done         <= 1'b1;
         error        <= 1'b1;
         err_timeout  <= 1'b1;
         err_address  <= ca.ca_address;
         err_expected <= expected;
         err_actual   <= '0;
      end else if (in_wait) begin
         wait_cnt <= wait_cnt + 32'd1;
      end else if (state > ST_DONE) begin
         state <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_cache_bist.sv
// Bench for cache_bist: behavioural cache model with random latency, a request
// scoreboard, pattern-generator vectors and the multi-cycle corner cases.
module tb_cache_bist;
   import cache_bist_pkg::*;

   localparam int          Aw      = 4;
   localparam int          Words   = 16;
   localparam int          Timeout = 1024;
   localparam logic [31:0] TbSeed  = 32'h0000_0000;

   typedef struct {
      logic [31:0] address;
      logic [3:0]  strobes;
      logic [31:0] data;
   } req_t;

   typedef struct {
      logic [31:0] address;
      pass_t       pass;
      logic        half_step;
      logic [31:0] data;
      logic [3:0]  strobes;
   } pg_vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        done, error, err_timeout;
   logic [31:0] err_address, err_expected, err_actual;

   logic [31:0] pg_address;
   pass_t       pg_pass;
   logic        pg_half;
   logic [31:0] pg_data;
   logic [3:0]  pg_strobes;

   int          checks = 0;
   int          errors = 0;
   req_t        sb_q[$];
   pg_vec_t     pg_vecs[6];
   logic [31:0] mem [Words];

   logic        stuck = 1'b1;
   logic        inject_fault = 1'b0;
   int          reads_14 = 0;
   int          accepts = 0;
   logic [11:0] strb_seq = '0;
   logic        pend_acc = 1'b0;
   logic        need_idle = 1'b0;
   logic        op_active = 1'b0;
   int          op_lat = 0;
   logic [31:0] op_address, op_data;
   logic [3:0]  op_strobes;

   cache_bist_if bif ();

   cache_bist #(.AddressBitWidth(Aw), .Seed(TbSeed), .TimeoutCycles(Timeout)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .done         (done),
      .error        (error),
      .err_timeout  (err_timeout),
      .err_address  (err_address),
      .err_expected (err_expected),
      .err_actual   (err_actual),
      .ca           (bif.master)
   );

   bist_pattern_gen #(.Seed(TbSeed)) u_pgen (
      .address   (pg_address),
      .pass      (pg_pass),
      .half_step (pg_half),
      .data      (pg_data),
      .strobes   (pg_strobes)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] tb_pattern(input logic [31:0] a);
      logic [15:0] lo;
      lo = a[15:0];
      return {lo, ~lo} ^ TbSeed;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: actual %h required %h", name, actual, required);
      end
   endtask

   // Cache model, evaluated once per falling edge; acceptance is predicted
   // here and confirmed at the following falling edge.
   task automatic model_step();
      req_t        exp_req;
      int          idx;
      logic [31:0] rdata;
      if (!rst_n) begin
         op_active = 1'b0;
         pend_acc  = 1'b0;
         need_idle = 1'b0;
         bif.ca_data_out_ready = 1'b0;
         bif.ca_data_out       = '0;
         bif.ca_busy           = stuck;
         return;
      end
      if (bif.ca_data_out_ready) begin
         bif.ca_data_out_ready = 1'b0;
         bif.ca_data_out       = '0;
      end
      if (!bif.ca_enable) need_idle = 1'b0;
      if (pend_acc) begin
         pend_acc   = 1'b0;
         accepts++;
         op_address = bif.ca_address;
         op_strobes = bif.ca_write_enable;
         op_data    = bif.ca_data_in;
         op_active  = 1'b1;
         op_lat     = $urandom_range(0, 2);
         if (op_address == 32'h3C && op_strobes != 4'b0000) strb_seq = {strb_seq[7:0], op_strobes};
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_request: actual address %h strobes %b, required none", op_address, op_strobes);
         end else begin
            exp_req = sb_q.pop_front();
            check_output("req_address", op_address, exp_req.address);
            check_output("req_strobes", {28'h0, op_strobes}, {28'h0, exp_req.strobes});
            if (exp_req.strobes != 4'b0000) check_output("req_data", op_data, exp_req.data);
         end
      end
      if (op_active) begin
         if (op_lat == 0) begin
            idx = int'(op_address[5:2]);
            if (op_strobes != 4'b0000) begin
               for (int b = 0; b < 4; b++) begin
                  if (op_strobes[b]) mem[idx][8*b +: 8] = op_data[8*b +: 8];
               end
            end else begin
               rdata = mem[idx];
               if (op_address == 32'h14) begin
                  if (inject_fault && reads_14 == 0) rdata[0] = ~rdata[0];
                  reads_14++;
               end
               bif.ca_data_out       = rdata;
               bif.ca_data_out_ready = 1'b1;
            end
            op_active = 1'b0;
         end else begin
            op_lat--;
         end
      end
      bif.ca_busy = stuck || op_active;
      if (bif.ca_enable && !bif.ca_busy && !need_idle) begin
         pend_acc  = 1'b1;
         need_idle = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
   endtask

   task automatic fill_expected();
      logic [31:0] a;
      sb_q.delete();
      for (int i = 0; i < Words; i++) begin
         a = 32'(i * 4);
         sb_q.push_back('{a, 4'b1111, tb_pattern(a)});
      end
      for (int i = 0; i < Words; i++) sb_q.push_back('{32'(i * 4), 4'b0000, 32'h0});
      for (int i = Words - 1; i >= 0; i--) begin
         a = 32'(i * 4);
         sb_q.push_back('{a, 4'b0011, ~tb_pattern(a)});
         sb_q.push_back('{a, 4'b1100, ~tb_pattern(a)});
      end
      for (int i = 0; i < Words; i++) sb_q.push_back('{32'(i * 4), 4'b0000, 32'h0});
   endtask

   task automatic apply_stimulus();
      fill_expected();
      accepts  = 0;
      strb_seq = '0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      int n = 0;
      while (!done && n < max_cycles) begin
         tick();
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL %s: done still 0 after %0d cycles, required 1", name, max_cycles);
      end
   endtask

   task automatic wait_accepts(input int target, input int max_cycles);
      int n = 0;
      while (accepts < target && n < max_cycles) begin
         tick();
         n++;
      end
      check_output("accept_wait", 32'(accepts >= target), 32'd1);
   endtask

   initial begin
      int n;
      bif.ca_busy           = 1'b1;
      bif.ca_data_out       = '0;
      bif.ca_data_out_ready = 1'b0;

      pg_vecs[0] = '{32'h0000_0000, PASS_W0, 1'b0, 32'h0000_FFFF, 4'b1111};
      pg_vecs[1] = '{32'h0000_0014, PASS_R0, 1'b0, 32'h0014_FFEB, 4'b0000};
      pg_vecs[2] = '{32'h0000_003C, PASS_W1, 1'b0, 32'hFFC3_003C, 4'b0011};
      pg_vecs[3] = '{32'h0000_003C, PASS_W1, 1'b1, 32'hFFC3_003C, 4'b1100};
      pg_vecs[4] = '{32'h0000_0004, PASS_R1, 1'b0, 32'hFFFB_0004, 4'b0000};
      pg_vecs[5] = '{32'h1234_5678, PASS_W0, 1'b0, 32'h5678_A987, 4'b1111};

      // Reset held with the cache reporting busy.
      for (int i = 0; i < 10; i++) begin
         tick();
         check_output("reset_enable", {31'h0, bif.ca_enable}, 32'h0);
      end
      check_output("reset_done", {31'h0, done}, 32'h0);
      check_output("reset_error", {30'h0, error, err_timeout}, 32'h0);
      check_output("reset_err_address", err_address, 32'h0);
      check_output("reset_err_expected", err_expected, 32'h0);
      check_output("reset_err_actual", err_actual, 32'h0);
      check_output("reset_strobes", {28'h0, bif.ca_write_enable}, 32'h0);
      check_output("reset_address", bif.ca_address, 32'h0);
      check_output("reset_data_in", bif.ca_data_in, 32'h0);

      for (int i = 0; i < 6; i++) begin
         pg_address = pg_vecs[i].address;
         pg_pass    = pg_vecs[i].pass;
         pg_half    = pg_vecs[i].half_step;
         #1;
         check_output($sformatf("pg_data_%0d", i), pg_data, pg_vecs[i].data);
         check_output($sformatf("pg_strobes_%0d", i), {28'h0, pg_strobes}, {28'h0, pg_vecs[i].strobes});
      end

      stuck = 1'b0;
      rst_n = 1'b1;
      tick();
      tick();

      // Full run with a stray start pulse in the middle of W1.
      apply_stimulus();
      check_output("enable_after_start", {31'h0, bif.ca_enable}, 32'h1);
      wait_accepts(40, 2000);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("run1_done", 2000);
      check_output("run1_error", {31'h0, error}, 32'h0);
      check_output("run1_accepts", 32'(accepts), 32'd80);
      check_output("run1_queue_empty", 32'(sb_q.size()), 32'd0);
      check_output("run1_w1_strobes_idx15", {20'h0, strb_seq}, 32'h0000_0F3C);
      check_output("run1_enable_idle", {31'h0, bif.ca_enable}, 32'h0);

      // Data mismatch on the R0 read of 0x14.
      inject_fault = 1'b1;
      reads_14     = 0;
      apply_stimulus();
      wait_done("fault_done", 2000);
      inject_fault = 1'b0;
      check_output("fault_error", {31'h0, error}, 32'h1);
      check_output("fault_timeout", {31'h0, err_timeout}, 32'h0);
      check_output("fault_err_address", err_address, 32'h0000_0014);
      check_output("fault_err_expected", err_expected, 32'h0014_FFEB);
      check_output("fault_err_actual", err_actual, 32'h0014_FFEA);
      check_output("fault_accepts", 32'(accepts), 32'd22);

      // Restart from Done clears the capture registers, then passes.
      apply_stimulus();
      check_output("restart_done_cleared", {31'h0, done}, 32'h0);
      check_output("restart_error_cleared", {30'h0, error, err_timeout}, 32'h0);
      check_output("restart_err_address", err_address, 32'h0);
      check_output("restart_err_expected", err_expected, 32'h0);
      check_output("restart_err_actual", err_actual, 32'h0);
      wait_done("run2_done", 2000);
      check_output("run2_error", {31'h0, error}, 32'h0);
      check_output("run2_accepts", 32'(accepts), 32'd80);

      // Cache stuck busy: the first request times out.
      stuck = 1'b1;
      apply_stimulus();
      n = 1;
      while (!done && n < 2000) begin
         tick();
         if (!done) n++;
      end
      check_output("timeout_issue_cycles", 32'(n), 32'(Timeout));
      check_output("timeout_done", {31'h0, done}, 32'h1);
      check_output("timeout_error", {30'h0, error, err_timeout}, 32'h3);
      check_output("timeout_err_address", err_address, 32'h0);
      check_output("timeout_err_expected", err_expected, 32'h0000_FFFF);
      check_output("timeout_err_actual", err_actual, 32'h0);
      stuck = 1'b0;
      tick();

      // Asynchronous reset while an R0 read is outstanding.
      apply_stimulus();
      wait_accepts(20, 2000);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_reset_enable", {31'h0, bif.ca_enable}, 32'h0);
      check_output("async_reset_address", bif.ca_address, 32'h0);
      check_output("async_reset_done", {31'h0, done}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      apply_stimulus();
      wait_done("run3_done", 2000);
      check_output("run3_error", {31'h0, error}, 32'h0);
      check_output("run3_accepts", 32'(accepts), 32'd80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
